tl_ul_buffer: RTL and testbench
===============================

Name: tl_ul_buffer

Overview:
- Parametrised TileLink-UL link buffer: independent A-channel (request) and D-channel (response) FIFOs between a client port and a manager port.
- Successor to the fixed-width combinational TL-UL pass-through stage. Adds configurable widths, per-channel depth, flow/pipe modes and occupancy status.
- Placed at bus-fabric crossings (core-to-periphery, debug-to-system) to break ready/valid timing paths.

Parameters:
- ADDR_W, 32, A address width.
- DATA_W, 32, data width; must be a multiple of 8. MASK_W = DATA_W/8.
- SOURCE_W, 4, source-ID width.
- SIZE_W, 3, size-field width.
- DEPTH_A, 2, A FIFO entries; 0 = combinational pass-through.
- DEPTH_D, 2, D FIFO entries; 0 = combinational pass-through.
- FLOW, 0, 1 = an empty FIFO forwards input to output in the same cycle.
- PIPE, 0, 1 = a full FIFO accepts input in the same cycle it is dequeued.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_a_valid  input  1  client request valid.
- in_a_ready  output  1  client request ready.
- in_a_bits  input  A_W  packed A payload {opcode[2:0], param[2:0], size, source, address, mask, data, corrupt}; A_W comes from the package.
- out_a_valid  output  1  manager request valid.
- out_a_ready  input  1  manager request ready.
- out_a_bits  output  A_W  A payload toward the manager.
- in_d_valid  input  1  manager response valid.
- in_d_ready  output  1  manager response ready.
- in_d_bits  input  D_W  packed D payload {opcode[2:0], param[1:0], size, source, denied, data, corrupt}.
- out_d_valid  output  1  client response valid.
- out_d_ready  input  1  client response ready.
- out_d_bits  output  D_W  D payload toward the client.
- a_count  output  clog2(DEPTH_A+1)  A occupancy.
- d_count  output  clog2(DEPTH_D+1)  D occupancy.

Behaviour:
- Reset and clocking:
  - Single clock domain. reset is synchronous, active-high; it has effect only at a clock edge.
- Transfer rules:
  - A transfer occurs when valid && ready in a cycle.
  - Payload is never modified, reordered or dropped. Each channel is strictly FIFO; the A and D channels are fully independent.
- Pass-through (DEPTH_x == 0):
  - out_valid = in_valid; in_ready = out_ready; out_bits = in_bits.
  - count is tied to 0. This mode has no state.
- Queue mode, state:
  - Circular buffer with wr_ptr and rd_ptr (each 0..DEPTH-1, wrapping from DEPTH-1 to 0) and a count register.
  - Full when count == DEPTH; empty when count == 0.
  - Non-power-of-two depths are legal; pointer wrap is explicit, not modulo-2^n.
- Queue mode, handshake:
  - Default: in_ready = !full; out_valid = !empty; out_bits = mem[rd_ptr].
  - Latency 1 cycle: data enqueued at edge N is visible at out at edge N.
- FLOW=1:
  - When empty: out_valid = in_valid and out_bits = in_bits.
  - If out_ready is also high, the entry bypasses storage and count stays 0.
- PIPE=1:
  - When full: in_ready = out_ready, so the FIFO dequeues and enqueues in the same cycle; count stays DEPTH.
- Simultaneous enqueue and dequeue:
  - When neither full nor empty: both pointers advance and count is unchanged.
- Count update:
  - count += enq && !deq; count -= deq && !enq.
  - Overflow or underflow is impossible by construction. The bench asserts it anyway.
- Reset values:
  - wr_ptr = rd_ptr = count = 0; out_valid = 0; a_count = d_count = 0.
  - in_ready is forced to 0 during any cycle where reset is high, and is 1 on the first cycle after reset deassertion.
  - Storage array is not reset.
- Reset mid-operation:
  - All queued entries are discarded. No output valid is asserted in the cycle after reset regardless of prior state.
- Protocol expectation:
  - out_valid, once asserted, stays high with stable bits until out_ready (valid/bits never depend on out_ready).

Decomposition:
- Package tl_ul_pkg:
  - Opcode constants: Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1.
  - Functions for the A_W/D_W width computation.
  - Packed A/D payload struct typedefs, parametrised through those functions.
- One sub-module tl_ul_queue:
  - Generic ready/valid FIFO with parameters WIDTH, DEPTH, FLOW, PIPE.
  - Instantiated once per channel; DEPTH=0 is handled inside it.
- The top level only packs widths and wires the two instances.

Test Plan:
- Reset then idle, DEPTH_A=2 -> in_a_ready=1, out_a_valid=0, a_count=0 on the first cycle after reset falls.
- Burst 3 Gets (source 1,2,3, address 0x1000/0x1004/0x1008) with out_a_ready=0, DEPTH_A=2 -> a_count=2, in_a_ready=0 after two accepts. Raise out_a_ready -> outputs in order 1,2,3.
- FLOW=1, empty, in_d_valid with AccessAckData data 0xDEADBEEF, out_d_ready=1 -> out_d_valid and out_d_bits match in the same cycle; d_count stays 0.
- PIPE=1, full A queue, out_a_ready=1 with in_a_valid=1 -> in_a_ready=1, a_count stays 2, order preserved across rd_ptr/wr_ptr wrap over 10 transfers.
- DEPTH_A=3, random valid/ready at 50% for 1000 transfers -> scoreboard matches, no loss or duplication, a_count never exceeds 3.
- Assert reset with 2 entries queued -> next cycle out_a_valid=0, a_count=0; a fresh entry (PutFullData, mask 0xF) emerges first.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// TileLink-UL shared definitions: opcodes, payload width helpers and default-width payload structs.
package tl_ul_pkg;

  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  // A: opcode, param, size, source, address, mask, data, corrupt
  function automatic int a_width(int addr_w, int data_w, int source_w, int size_w);
    return 3 + 3 + size_w + source_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  // D: opcode, param, size, source, denied, data, corrupt
  function automatic int d_width(int data_w, int source_w, int size_w);
    return 3 + 2 + size_w + source_w + 1 + data_w + 1;
  endfunction

  // A zero-depth queue still exposes a 1-bit count tied to zero.
  function automatic int cnt_width(int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

  localparam int TL_ADDR_W   = 32;
  localparam int TL_DATA_W   = 32;
  localparam int TL_SOURCE_W = 4;
  localparam int TL_SIZE_W   = 3;
  localparam int TL_MASK_W   = TL_DATA_W / 8;
  localparam int TL_A_W      = a_width(TL_ADDR_W, TL_DATA_W, TL_SOURCE_W, TL_SIZE_W);
  localparam int TL_D_W      = d_width(TL_DATA_W, TL_SOURCE_W, TL_SIZE_W);

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic [TL_ADDR_W-1:0]   address;
    logic [TL_MASK_W-1:0]   mask;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
    logic                   corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_ul_queue.sv
// Generic ready/valid FIFO with optional same-cycle flow-through and pipe-when-full;
// DEPTH=0 degenerates to a stateless wire.
module tl_ul_queue
  import tl_ul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_bits,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_bits,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_bits  = in_bits;
    assign count     = '0;
  end else begin : g_fifo
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full, empty, enq, deq;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign enq   = in_valid && in_ready;
    assign deq   = out_valid && out_ready;
    assign count = cnt;

    // Handshakes are held off while reset is high so nothing is accepted or consumed.
    always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_bits  = mem[rd_ptr];
      if (!reset) begin
        in_ready  = !full || (PIPE != 0 && out_ready);
        out_valid = !empty || (FLOW != 0 && in_valid);
      end
      if (FLOW != 0 && empty) out_bits = in_bits;
    end

    // A flow-through bypass advances both pointers together, leaving count untouched.
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (enq) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (deq) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (enq && !deq)      cnt <= cnt + 1'b1;
        else if (deq && !enq) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (enq) mem[wr_ptr] <= in_bits;
    end
  end

endmodule

// File: rtl/tl_ul_buffer.sv
// TileLink-UL link buffer: independent A (request) and D (response) queues between
// a client and a manager, used to cut ready/valid timing paths at fabric crossings.
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 3,
  parameter int DEPTH_A  = 2,
  parameter int DEPTH_D  = 2,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 in_a_valid,
  output logic                                                 in_a_ready,
  input  logic [a_width(ADDR_W, DATA_W, SOURCE_W, SIZE_W)-1:0] in_a_bits,
  output logic                                                 out_a_valid,
  input  logic                                                 out_a_ready,
  output logic [a_width(ADDR_W, DATA_W, SOURCE_W, SIZE_W)-1:0] out_a_bits,
  input  logic                                                 in_d_valid,
  output logic                                                 in_d_ready,
  input  logic [d_width(DATA_W, SOURCE_W, SIZE_W)-1:0]         in_d_bits,
  output logic                                                 out_d_valid,
  input  logic                                                 out_d_ready,
  output logic [d_width(DATA_W, SOURCE_W, SIZE_W)-1:0]         out_d_bits,
  output logic [cnt_width(DEPTH_A)-1:0]                        a_count,
  output logic [cnt_width(DEPTH_D)-1:0]                        d_count
);

  localparam int A_W = a_width(ADDR_W, DATA_W, SOURCE_W, SIZE_W);
  localparam int D_W = d_width(DATA_W, SOURCE_W, SIZE_W);

  tl_ul_queue #(
    .WIDTH (A_W),
    .DEPTH (DEPTH_A),
    .FLOW  (FLOW),
    .PIPE  (PIPE)
  ) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_a_valid),
    .in_ready  (in_a_ready),
    .in_bits   (in_a_bits),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .out_bits  (out_a_bits),
    .count     (a_count)
  );

  tl_ul_queue #(
    .WIDTH (D_W),
    .DEPTH (DEPTH_D),
    .FLOW  (FLOW),
    .PIPE  (PIPE)
  ) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_d_valid),
    .in_ready  (in_d_ready),
    .in_bits   (in_d_bits),
    .out_valid (out_d_valid),
    .out_ready (out_d_ready),
    .out_bits  (out_d_bits),
    .count     (d_count)
  );

endmodule

// File: tb/tb_tl_ul_buffer.sv
// Bench for tl_ul_buffer: dut1 (depth 2, FLOW=1, PIPE=1) and dut2 (A depth 3, D pass-through).
module tb_tl_ul_buffer;
  import tl_ul_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // dut1
  logic       p1_rst, p1_in_a_valid, p1_in_a_ready, p1_out_a_valid, p1_out_a_ready;
  logic       p1_in_d_valid, p1_in_d_ready, p1_out_d_valid, p1_out_d_ready;
  tl_a_t      p1_in_a_bits, p1_out_a_bits;
  tl_d_t      p1_in_d_bits, p1_out_d_bits;
  logic [1:0] p1_a_count, p1_d_count;
  // dut2
  logic       p2_rst, p2_in_a_valid, p2_in_a_ready, p2_out_a_valid, p2_out_a_ready;
  logic       p2_in_d_valid, p2_in_d_ready, p2_out_d_valid, p2_out_d_ready;
  tl_a_t      p2_in_a_bits, p2_out_a_bits;
  tl_d_t      p2_in_d_bits, p2_out_d_bits;
  logic [1:0] p2_a_count;
  logic [0:0] p2_d_count;

  tl_ul_buffer #(.DEPTH_A(2), .DEPTH_D(2), .FLOW(1), .PIPE(1)) u_dut1 (
    .clock(clock), .reset(p1_rst),
    .in_a_valid(p1_in_a_valid), .in_a_ready(p1_in_a_ready), .in_a_bits(p1_in_a_bits),
    .out_a_valid(p1_out_a_valid), .out_a_ready(p1_out_a_ready), .out_a_bits(p1_out_a_bits),
    .in_d_valid(p1_in_d_valid), .in_d_ready(p1_in_d_ready), .in_d_bits(p1_in_d_bits),
    .out_d_valid(p1_out_d_valid), .out_d_ready(p1_out_d_ready), .out_d_bits(p1_out_d_bits),
    .a_count(p1_a_count), .d_count(p1_d_count)
  );

  tl_ul_buffer #(.DEPTH_A(3), .DEPTH_D(0), .FLOW(0), .PIPE(0)) u_dut2 (
    .clock(clock), .reset(p2_rst),
    .in_a_valid(p2_in_a_valid), .in_a_ready(p2_in_a_ready), .in_a_bits(p2_in_a_bits),
    .out_a_valid(p2_out_a_valid), .out_a_ready(p2_out_a_ready), .out_a_bits(p2_out_a_bits),
    .in_d_valid(p2_in_d_valid), .in_d_ready(p2_in_d_ready), .in_d_bits(p2_in_d_bits),
    .out_d_valid(p2_out_d_valid), .out_d_ready(p2_out_d_ready), .out_d_bits(p2_out_d_bits),
    .a_count(p2_a_count), .d_count(p2_d_count)
  );

  // staged stimulus, applied to the DUT on the next falling edge
  logic  s1_rst, s1_a_iv, s1_a_or, s1_d_iv, s1_d_or;
  tl_a_t s1_a_ib;
  tl_d_t s1_d_ib;
  logic  s2_rst, s2_a_iv, s2_a_or, s2_d_iv, s2_d_or;
  tl_a_t s2_a_ib;
  tl_d_t s2_d_ib;

  // scoreboards and occupancy models
  tl_a_t sb1a[$];
  tl_d_t sb1d[$];
  tl_a_t sb2a[$];
  tl_a_t log1a[$];
  int    cnt1a = 0, cnt1d = 0, cnt2a = 0, n_out2 = 0;
  logic  acc2;
  logic  prv_ov = 1'b0, prv_or = 1'b0;
  tl_a_t prv_ob;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tl_a_t mk_a(input logic [2:0] op, input logic [3:0] src,
                                 input logic [31:0] addr, input logic [3:0] mask,
                                 input logic [31:0] data);
    tl_a_t a;
    a = '0;
    a.opcode = op; a.size = 3'd2; a.source = src;
    a.address = addr; a.mask = mask; a.data = data;
    return a;
  endfunction

  function automatic tl_d_t mk_d(input logic [2:0] op, input logic [3:0] src, input logic [31:0] data);
    tl_d_t d;
    d = '0;
    d.opcode = op; d.size = 3'd2; d.source = src; d.data = data;
    return d;
  endfunction

  task automatic apply1();
    p1_rst = s1_rst;
    p1_in_a_valid = s1_a_iv; p1_in_a_bits = s1_a_ib; p1_out_a_ready = s1_a_or;
    p1_in_d_valid = s1_d_iv; p1_in_d_bits = s1_d_ib; p1_out_d_ready = s1_d_or;
  endtask

  task automatic apply2();
    p2_rst = s2_rst;
    p2_in_a_valid = s2_a_iv; p2_in_a_bits = s2_a_ib; p2_out_a_ready = s2_a_or;
    p2_in_d_valid = s2_d_iv; p2_in_d_bits = s2_d_ib; p2_out_d_ready = s2_d_or;
  endtask

  task automatic tick1();
    logic  a_enq, a_deq, d_enq, d_deq;
    tl_a_t ea;
    tl_d_t ed;
    @(negedge clock);
    apply1();
    #1;
    check("a1_count", p1_a_count, cnt1a);
    check("a1_count_max", p1_a_count <= 2'd2, 1'b1);
    check("a1_in_ready", p1_in_a_ready, !s1_rst && (cnt1a < 2 || s1_a_or));
    check("a1_out_valid", p1_out_a_valid, !s1_rst && (cnt1a > 0 || s1_a_iv));
    check("d1_count", p1_d_count, cnt1d);
    check("d1_in_ready", p1_in_d_ready, !s1_rst && (cnt1d < 2 || s1_d_or));
    check("d1_out_valid", p1_out_d_valid, !s1_rst && (cnt1d > 0 || s1_d_iv));
    a_enq = p1_in_a_valid && p1_in_a_ready;
    a_deq = p1_out_a_valid && p1_out_a_ready;
    d_enq = p1_in_d_valid && p1_in_d_ready;
    d_deq = p1_out_d_valid && p1_out_d_ready;
    if (a_enq) sb1a.push_back(s1_a_ib);
    if (d_enq) sb1d.push_back(s1_d_ib);
    if (a_deq) begin
      check("a1_no_underflow", sb1a.size() > 0, 1'b1);
      if (sb1a.size() > 0) begin
        ea = sb1a.pop_front();
        check("a1_bits", p1_out_a_bits, ea);
        log1a.push_back(p1_out_a_bits);
      end
    end
    if (d_deq) begin
      check("d1_no_underflow", sb1d.size() > 0, 1'b1);
      if (sb1d.size() > 0) begin
        ed = sb1d.pop_front();
        check("d1_bits", p1_out_d_bits, ed);
      end
    end
    if (s1_rst) begin
      cnt1a = 0; cnt1d = 0;
      sb1a.delete(); sb1d.delete();
    end else begin
      cnt1a = cnt1a + int'(a_enq) - int'(a_deq);
      cnt1d = cnt1d + int'(d_enq) - int'(d_deq);
    end
  endtask

  task automatic tick2();
    logic  a_deq;
    tl_a_t ea;
    @(negedge clock);
    apply2();
    #1;
    check("a2_count", p2_a_count, cnt2a);
    check("a2_count_max", p2_a_count <= 2'd3, 1'b1);
    check("a2_in_ready", p2_in_a_ready, !s2_rst && cnt2a < 3);
    check("a2_out_valid", p2_out_a_valid, !s2_rst && cnt2a > 0);
    if (prv_ov && !prv_or && !s2_rst) begin
      check("a2_hold_valid", p2_out_a_valid, 1'b1);
      check("a2_hold_bits", p2_out_a_bits, prv_ob);
    end
    check("d2_pass_valid", p2_out_d_valid, s2_d_iv);
    check("d2_pass_ready", p2_in_d_ready, s2_d_or);
    check("d2_pass_bits", p2_out_d_bits, s2_d_ib);
    check("d2_count", p2_d_count, 1'b0);
    acc2  = p2_in_a_valid && p2_in_a_ready;
    a_deq = p2_out_a_valid && p2_out_a_ready;
    if (acc2) sb2a.push_back(s2_a_ib);
    if (a_deq) begin
      check("a2_no_underflow", sb2a.size() > 0, 1'b1);
      if (sb2a.size() > 0) begin
        ea = sb2a.pop_front();
        check("a2_bits", p2_out_a_bits, ea);
        n_out2++;
      end
    end
    prv_ov = p2_out_a_valid; prv_or = s2_a_or; prv_ob = p2_out_a_bits;
    if (s2_rst) begin
      cnt2a = 0; sb2a.delete();
    end else begin
      cnt2a = cnt2a + int'(acc2) - int'(a_deq);
    end
  endtask

  initial begin
    logic        pend;
    int          cyc;
    logic [95:0] ra;
    logic [63:0] rd;

    s1_rst = 1'b1; s1_a_iv = 1'b0; s1_a_or = 1'b0; s1_d_iv = 1'b0; s1_d_or = 1'b0;
    s1_a_ib = '0; s1_d_ib = '0;
    s2_rst = 1'b1; s2_a_iv = 1'b0; s2_a_or = 1'b0; s2_d_iv = 1'b0; s2_d_or = 1'b0;
    s2_a_ib = '0; s2_d_ib = '0;
    apply1();
    apply2();

    // reset, then first idle cycle
    tick1();
    tick1();
    check("rst_in_a_ready_low", p1_in_a_ready, 1'b0);
    s1_rst = 1'b0;
    tick1();
    check("post_rst_in_a_ready", p1_in_a_ready, 1'b1);
    check("post_rst_out_a_valid", p1_out_a_valid, 1'b0);
    check("post_rst_a_count", p1_a_count, 2'd0);

    // burst of three Gets into a stalled depth-2 queue
    log1a.delete();
    s1_a_iv = 1'b1; s1_a_or = 1'b0;
    s1_a_ib = mk_a(OP_GET, 4'd1, 32'h1000, 4'hF, 32'h0); tick1();
    s1_a_ib = mk_a(OP_GET, 4'd2, 32'h1004, 4'hF, 32'h0); tick1();
    s1_a_ib = mk_a(OP_GET, 4'd3, 32'h1008, 4'hF, 32'h0); tick1();
    check("burst_a_count_full", p1_a_count, 2'd2);
    check("burst_in_a_ready_full", p1_in_a_ready, 1'b0);
    s1_a_or = 1'b1; tick1();
    s1_a_iv = 1'b0;
    tick1(); tick1(); tick1();
    check("burst_out_count", log1a.size(), 3);
    if (log1a.size() == 3) begin
      check("burst_order_0", log1a[0].source, 4'd1);
      check("burst_order_1", log1a[1].source, 4'd2);
      check("burst_order_2", log1a[2].source, 4'd3);
      check("burst_addr_2", log1a[2].address, 32'h1008);
    end

    // FLOW: empty D queue forwards in the same cycle
    s1_d_iv = 1'b1; s1_d_or = 1'b1;
    s1_d_ib = mk_d(OP_ACCESS_ACK_DATA, 4'd5, 32'hDEADBEEF);
    tick1();
    check("flow_d_valid", p1_out_d_valid, 1'b1);
    check("flow_d_data", p1_out_d_bits.data, 32'hDEADBEEF);
    check("flow_d_opcode", p1_out_d_bits.opcode, OP_ACCESS_ACK_DATA);
    s1_d_iv = 1'b0;
    tick1();
    check("flow_d_count_zero", p1_d_count, 2'd0);

    // D queue fill to full then drain
    s1_d_iv = 1'b1; s1_d_or = 1'b0;
    s1_d_ib = mk_d(OP_ACCESS_ACK, 4'd6, 32'h0); tick1();
    s1_d_ib = mk_d(OP_ACCESS_ACK_DATA, 4'd7, 32'h1234_5678); tick1();
    s1_d_iv = 1'b0; tick1();
    check("d_fill_count", p1_d_count, 2'd2);
    s1_d_or = 1'b1;
    tick1(); tick1(); tick1();

    // PIPE: full queue streams 10 transfers across pointer wrap
    s1_a_iv = 1'b1; s1_a_or = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s1_a_ib = mk_a(OP_PUT_FULL_DATA, 4'(i), 32'h2000 + 32'(i * 4), 4'hF, 32'hA000 + 32'(i));
      tick1();
    end
    s1_a_or = 1'b1;
    for (int i = 2; i < 12; i++) begin
      s1_a_ib = mk_a(OP_PUT_FULL_DATA, 4'(i), 32'h2000 + 32'(i * 4), 4'hF, 32'hA000 + 32'(i));
      tick1();
      check("pipe_in_ready", p1_in_a_ready, 1'b1);
      check("pipe_count", p1_a_count, 2'd2);
    end
    s1_a_iv = 1'b0;
    tick1(); tick1(); tick1();
    check("pipe_drained", sb1a.size(), 0);

    // reset with two entries queued
    s1_a_iv = 1'b1; s1_a_or = 1'b0;
    s1_a_ib = mk_a(OP_GET, 4'd9, 32'h3000, 4'hF, 32'h0); tick1();
    s1_a_ib = mk_a(OP_GET, 4'd10, 32'h3004, 4'hF, 32'h0); tick1();
    s1_a_iv = 1'b0; s1_rst = 1'b1;
    tick1();
    check("midrst_in_ready", p1_in_a_ready, 1'b0);
    s1_rst = 1'b0;
    tick1();
    check("midrst_out_valid", p1_out_a_valid, 1'b0);
    check("midrst_count", p1_a_count, 2'd0);
    log1a.delete();
    s1_a_iv = 1'b1;
    s1_a_ib = mk_a(OP_PUT_FULL_DATA, 4'd11, 32'h4000, 4'hF, 32'hCAFE_F00D);
    tick1();
    s1_a_iv = 1'b0; s1_a_or = 1'b1;
    tick1();
    check("midrst_first_out", log1a.size(), 1);
    if (log1a.size() > 0) begin
      check("midrst_opcode", log1a[0].opcode, OP_PUT_FULL_DATA);
      check("midrst_mask", log1a[0].mask, 4'hF);
      check("midrst_source", log1a[0].source, 4'd11);
    end

    // dut2: depth-3 A queue under random handshakes, D pass-through
    tick2();
    s2_rst = 1'b0;
    tick2();
    check("d2_post_rst_ready", p2_in_a_ready, 1'b1);
    pend = 1'b0;
    cyc  = 0;
    while (n_out2 < 1000 && cyc < 20000) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        ra = {$urandom, $urandom, $urandom};
        s2_a_ib = tl_a_t'(ra[TL_A_W-1:0]);
      end
      s2_a_iv = pend;
      s2_a_or = ($urandom_range(0, 1) == 1);
      rd = {$urandom, $urandom};
      s2_d_ib = tl_d_t'(rd[TL_D_W-1:0]);
      s2_d_iv = ($urandom_range(0, 1) == 1);
      s2_d_or = ($urandom_range(0, 1) == 1);
      tick2();
      if (acc2) pend = 1'b0;
      cyc++;
    end
    check("rand_transfers_done", n_out2 >= 1000, 1'b1);
    s2_a_iv = 1'b0; s2_a_or = 1'b1;
    for (int i = 0; i < 5; i++) tick2();
    check("rand_no_loss", sb2a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
